// File: rtl/pwm_deadtime_driver.sv
// Complementary high/low gate-drive generator with programmable dead time,
// short-pulse swallowing and a sticky fault latch.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_OFF  | both outputs low; waits for enable and a clear fault latch
// S_DT_H | dead time before driving the high side
// S_HIGH | high side driven
// S_DT_L | dead time before driving the low side
// S_LOW  | low side driven
module pwm_deadtime_driver #(
  parameter int DT_W   = 16,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pwm_in,
  input  logic [DT_W-1:0]   dead_time,
  input  logic              fault_in,
  input  logic              fault_clr,
  output logic              out_h,
  output logic              out_l,
  output logic              fault_latched,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_DT_H = 3'd1,
    S_HIGH = 3'd2,
    S_DT_L = 3'd3,
    S_LOW  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DT_W-1:0]   cnt_q, cnt_d;
  logic              from_off_q, from_off_d;
  logic              fault_q, fault_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              out_h_q, out_l_q;
  logic              drop_sat;

  assign drop_sat = &drop_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_off_d = from_off_q;
    fault_d    = fault_q;
    drop_d     = drop_q;

    if (fault_in) begin
      state_d = S_OFF;
      fault_d = 1'b1;
    end else begin
      if (fault_clr) begin
        fault_d = 1'b0;
      end
      if (!enable) begin
        state_d = S_OFF;
      end else begin
        // The OFF check uses the old latch value so a clear holds OFF one more edge.
        case (state_q)
          S_OFF: begin
            if (!fault_q) begin
              state_d    = pwm_in ? S_DT_H : S_DT_L;
              cnt_d      = dead_time;
              from_off_d = 1'b1;
            end
          end
          S_LOW: begin
            if (pwm_in) begin
              state_d    = S_DT_H;
              cnt_d      = dead_time;
              from_off_d = 1'b0;
            end
          end
          S_HIGH: begin
            if (!pwm_in) begin
              state_d    = S_DT_L;
              cnt_d      = dead_time;
              from_off_d = 1'b0;
            end
          end
          S_DT_H: begin
            if (!pwm_in) begin
              // Leaving OFF no side was on yet: retarget with a full dead time instead.
              if (from_off_q) begin
                state_d = S_DT_L;
                cnt_d   = dead_time;
              end else begin
                state_d = S_LOW;
                if (!drop_sat) begin
                  drop_d = drop_q + DROP_W'(1);
                end
              end
            end else if (cnt_q <= DT_W'(1)) begin
              state_d = S_HIGH;
            end else begin
              cnt_d = cnt_q - DT_W'(1);
            end
          end
          S_DT_L: begin
            if (pwm_in) begin
              if (from_off_q) begin
                state_d = S_DT_H;
                cnt_d   = dead_time;
              end else begin
                state_d = S_HIGH;
                if (!drop_sat) begin
                  drop_d = drop_q + DROP_W'(1);
                end
              end
            end else if (cnt_q <= DT_W'(1)) begin
              state_d = S_LOW;
            end else begin
              cnt_d = cnt_q - DT_W'(1);
            end
          end
          default: begin
            state_d = S_OFF;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      from_off_q <= 1'b0;
      fault_q    <= 1'b0;
      drop_q     <= '0;
      out_h_q    <= 1'b0;
      out_l_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_off_q <= from_off_d;
      fault_q    <= fault_d;
      drop_q     <= drop_d;
      out_h_q    <= (state_d == S_HIGH);
      out_l_q    <= (state_d == S_LOW);
    end
  end

  assign out_h         = out_h_q;
  assign out_l         = out_l_q;
  assign fault_latched = fault_q;
  assign drop_cnt      = drop_q;

endmodule
